// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: one outstanding word read to imem, valid/ready hand-off to decode,
// PC stall generation, redirect squash and sticky misaligned-fetch fault.
module instr_fetch_unit #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_addr,
  output logic        pc_stall,
  input  logic        redirect,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_addr,
  input  logic        instr_ready,
  output logic        fetch_fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_addr_q, instr_addr_d;
  logic        misaligned;
  logic        req_fire;

  assign misaligned = (pc_addr[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
    end
  end

  // Next-state logic; redirect takes priority over every other event
  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (redirect)            state_d = S_REQ;
        else if (misaligned)     state_d = S_FAULT;
        else if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response arriving with a redirect, or after one, belongs to the squashed path
        if (imem_resp_valid) begin
          state_d   = (redirect || discard_q) ? S_REQ : S_HOLD;
          discard_d = 1'b0;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect || instr_ready) state_d = S_REQ;
      end
      S_FAULT: begin
        if (redirect) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req_valid = !rst && (state_q == S_REQ) && !redirect && !misaligned;
    imem_req_addr  = imem_req_valid ? pc_addr : 32'h0;
    pc_stall       = rst || !(redirect || ((state_q == S_HOLD) && instr_ready));
    instr_valid    = (state_q == S_HOLD);
    fetch_fault    = (state_q == S_FAULT);
  end

  assign req_fire = imem_req_valid && imem_req_ready;

  // Datapath: request address latch and delivered instruction
  always_comb begin
    req_addr_d   = req_addr_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    if (req_fire) req_addr_d = pc_addr;
    if ((state_q == S_WAIT) && (state_d == S_HOLD)) begin
      instr_d      = imem_resp_data;
      instr_addr_d = req_addr_q;
    end else if (state_d != S_HOLD) begin
      instr_d      = NOP_INSTR;
      instr_addr_d = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr_q   <= 32'h0;
      instr_q      <= NOP_INSTR;
      instr_addr_q <= 32'h0;
    end else begin
      req_addr_q   <= req_addr_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
    end
  end

  assign instr      = instr_q;
  assign instr_addr = instr_addr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed cycle-table bench for instr_fetch_unit plus a bounded hand-written fetch sequence.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_addr;
  logic        pc_stall;
  logic        redirect;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_addr;
  logic        instr_ready;
  logic        fetch_fault;

  int checks   = 0;
  int failures = 0;

  instr_fetch_unit dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_stall(pc_stall), .redirect(redirect),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .instr_valid(instr_valid), .instr(instr),
    .instr_addr(instr_addr), .instr_ready(instr_ready), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        rd, rq, rv;
    logic [31:0] rdat;
    logic        ir;
    logic        st, qv;
    logic [31:0] qa;
    logic        iv;
    logic [31:0] ins, ia;
    logic        ff;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic [31:0] pc, input logic rd, rq, rv,
                              input logic [31:0] rdat, input logic ir,
                              input logic st, qv, input logic [31:0] qa, input logic iv,
                              input logic [31:0] ins, ia, input logic ff);
    vec_t v;
    v.rst = r; v.pc = pc; v.rd = rd; v.rq = rq; v.rv = rv; v.rdat = rdat; v.ir = ir;
    v.st = st; v.qv = qv; v.qa = qa; v.iv = iv; v.ins = ins; v.ia = ia; v.ff = ff;
    tbl.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    rst = v.rst; pc_addr = v.pc; redirect = v.rd; imem_req_ready = v.rq;
    imem_resp_valid = v.rv; imem_resp_data = v.rdat; instr_ready = v.ir;
    #4;
    checks++;
    if ({pc_stall, imem_req_valid, imem_req_addr, instr_valid, instr, instr_addr, fetch_fault} !==
        {v.st, v.qv, v.qa, v.iv, v.ins, v.ia, v.ff}) begin
      failures++;
      $display("FAIL row%0d actual st=%b qv=%b qa=%h iv=%b ins=%h ia=%h ff=%b expected st=%b qv=%b qa=%h iv=%b ins=%h ia=%h ff=%b",
               idx, pc_stall, imem_req_valid, imem_req_addr, instr_valid, instr, instr_addr, fetch_fault,
               v.st, v.qv, v.qa, v.iv, v.ins, v.ia, v.ff);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    bit got;
    rst = 1'b1; pc_addr = '0; redirect = 1'b0; imem_req_ready = 1'b0;
    imem_resp_valid = 1'b0; imem_resp_data = '0; instr_ready = 1'b0;
    @(posedge clk); #1;

    // rst   pc        rd rq rv data          ir   st qv addr      iv instr         iaddr     ff
    // reset, then best-case fetch at 0
    add(1, 32'h0,  0, 0, 0, 32'h0,         0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h0,  0, 0, 0, 32'h0,         1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h0,  0, 1, 0, 32'h0,         1,   1, 1, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h0,  0, 0, 1, 32'h12345678,  1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h0,  0, 0, 0, 32'h0,         1,   0, 0, 32'h0,  1, 32'h12345678,  32'h0,  0);
    add(0, 32'h4,  0, 1, 0, 32'h0,         0,   1, 1, 32'h4,  0, 32'h0,         32'h0,  0);
    add(0, 32'h4,  0, 0, 1, 32'hAAAA0001,  0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    // decode backpressure for 5 cycles, then a single advance
    for (int i = 0; i < 5; i++)
      add(0, 32'h4, 0, 1, 0, 32'h0,        0,   1, 0, 32'h0,  1, 32'hAAAA0001,  32'h4,  0);
    add(0, 32'h4,  0, 1, 0, 32'h0,         1,   0, 0, 32'h0,  1, 32'hAAAA0001,  32'h4,  0);
    // memory not ready 3 cycles, then 4-cycle response latency
    for (int i = 0; i < 3; i++)
      add(0, 32'h8, 0, 0, 0, 32'h0,        0,   1, 1, 32'h8,  0, 32'h0,         32'h0,  0);
    add(0, 32'h8,  0, 1, 0, 32'h0,         0,   1, 1, 32'h8,  0, 32'h0,         32'h0,  0);
    for (int i = 0; i < 3; i++)
      add(0, 32'h8, 0, 0, 0, 32'h0,        1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h8,  0, 0, 1, 32'hBBBB0008,  1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h8,  0, 0, 0, 32'h0,         1,   0, 0, 32'h0,  1, 32'hBBBB0008,  32'h8,  0);
    // redirect in WAIT: response for 0xC is discarded later
    add(0, 32'hC,  0, 1, 0, 32'h0,         1,   1, 1, 32'hC,  0, 32'h0,         32'h0,  0);
    add(0, 32'hC,  1, 0, 0, 32'h0,         1,   0, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h40, 0, 0, 0, 32'h0,         1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h40, 0, 0, 1, 32'hDEAD000C,  1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h40, 0, 1, 0, 32'h0,         1,   1, 1, 32'h40, 0, 32'h0,         32'h0,  0);
    add(0, 32'h40, 0, 0, 1, 32'hCCCC0040,  1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h40, 0, 0, 0, 32'h0,         1,   0, 0, 32'h0,  1, 32'hCCCC0040,  32'h40, 0);
    // redirect coincident with response
    add(0, 32'h44, 0, 1, 0, 32'h0,         1,   1, 1, 32'h44, 0, 32'h0,         32'h0,  0);
    add(0, 32'h44, 1, 0, 1, 32'hDEAD0044,  1,   0, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h80, 0, 1, 0, 32'h0,         0,   1, 1, 32'h80, 0, 32'h0,         32'h0,  0);
    add(0, 32'h80, 0, 0, 1, 32'h11110080,  0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    // redirect in HOLD with decode not ready
    add(0, 32'h80, 1, 0, 0, 32'h0,         0,   0, 0, 32'h0,  1, 32'h11110080,  32'h80, 0);
    // misaligned PC -> sticky fault until redirect
    add(0, 32'h6,  0, 1, 0, 32'h0,         0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h6,  0, 1, 0, 32'h0,         0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  1);
    add(0, 32'h6,  0, 1, 0, 32'h0,         0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  1);
    add(0, 32'h6,  1, 1, 0, 32'h0,         0,   0, 0, 32'h0,  0, 32'h0,         32'h0,  1);
    add(0, 32'h10, 0, 1, 0, 32'h0,         0,   1, 1, 32'h10, 0, 32'h0,         32'h0,  0);
    // reset while outstanding, stray late response ignored
    add(0, 32'h10, 0, 0, 0, 32'h0,         0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(1, 32'h10, 0, 0, 0, 32'h0,         0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h10, 0, 1, 1, 32'hDEAD0010,  1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h0,  0, 1, 0, 32'h0,         1,   1, 1, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h0,  0, 0, 1, 32'h22220000,  1,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h0,  0, 0, 0, 32'h0,         1,   0, 0, 32'h0,  1, 32'h22220000,  32'h0,  0);
    // redirect in REQ suppresses the request
    add(0, 32'h4,  1, 1, 0, 32'h0,         0,   0, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h20, 0, 1, 0, 32'h0,         0,   1, 1, 32'h20, 0, 32'h0,         32'h0,  0);
    // two redirects while waiting: a single discard
    add(0, 32'h20, 1, 0, 0, 32'h0,         0,   0, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h30, 1, 0, 0, 32'h0,         0,   0, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h30, 0, 0, 1, 32'hDEAD0020,  0,   1, 0, 32'h0,  0, 32'h0,         32'h0,  0);
    add(0, 32'h30, 0, 0, 0, 32'h0,         0,   1, 1, 32'h30, 0, 32'h0,         32'h0,  0);

    foreach (tbl[i]) apply(tbl[i], i);

    // Hand sequence: complete the pending fetch at 0x30 and wait a bounded time for delivery
    pc_addr = 32'h30; imem_req_ready = 1'b1; redirect = 1'b0; imem_resp_valid = 1'b0; instr_ready = 1'b0;
    #4;
    check("req_addr_30", imem_req_addr, 32'h30);
    @(posedge clk); #1;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'h33330030;
    @(posedge clk); #1;
    imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      #3;
      if (instr_valid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("deliver_timeout", {31'h0, got}, 32'h1);
    check("instr_30", instr, 32'h33330030);
    check("instr_addr_30", instr_addr, 32'h30);
    check("stall_held", {31'h0, pc_stall}, 32'h1);
    instr_ready = 1'b1;
    #1;
    check("stall_release", {31'h0, pc_stall}, 32'h0);
    @(posedge clk); #1;
    instr_ready = 1'b0;
    #3;
    check("instr_nop_after", instr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
